multicycle_controller: RTL
==========================

# multicycle_controller

Control FSM for the 16-bit multi-cycle accumulator processor; sits directly upstream of the ALU and drives its `ALUControl` plus the operand muxes in front of `SrcA`/`SrcB`. It sequences fetch, decode, memory access and execute for the 3-bit-opcode instruction set, handshakes with a variable-latency memory via `mem_ready`, and consumes the ALU `zero` flag for conditional branches. A watchdog halts the core if memory stops responding.

## Interface
- `MEM_TIMEOUT`, default 15: maximum consecutive wait cycles per memory request before halting; 0 disables the watchdog.
- Reset is asynchronous and active-high; one clock domain.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `opcode` input 3: `IR[15:13]`, valid from DECODE onward.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current request at this edge.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `i_or_d` output 1: address select; 0 = PC, 1 = `IR[12:0]` zero-extended.
- `ir_write` output 1: load IR from memory data.
- `mdr_write` output 1: load MDR from memory data.
- `acc_write` output 1: load ACC from `ALUResult`.
- `pc_write` output 1: load PC from `ALUResult`.
- `alu_src_a` output 1: 0 = PC, 1 = ACC.
- `alu_src_b` output 2: 0 = MDR, 1 = constant 1, 2 = `IR[12:0]` zero-extended; 3 is never driven.
- `alu_control` output 3: ALU opcode, using the ALU's encoding: 000 add, 001 sub, 010 and, 011 or, 100 not A, 101 pass A, 110 pass B.
- `instr_done` output 1: one-cycle pulse on the last cycle of each instruction.
- `halted` output 1: sticky; set on memory timeout.

## Operation
- Opcodes:
  - 000 LOAD: ACC ← M[adr]
  - 001 STORE: M[adr] ← ACC
  - 010 ADD: ACC ← ACC + M[adr]
  - 011 SUB: ACC ← ACC − M[adr]
  - 100 AND: ACC ← ACC & M[adr]
  - 101 NOT: ACC ← ~ACC
  - 110 JMP: PC ← adr
  - 111 JZ: PC ← adr if ACC == 0
- States: INIT, FETCH, DECODE, MEMRD, EXEC, STORE, JUMP, BRZ, HALT.
- INIT: all outputs 0; unconditionally → FETCH.
- FETCH:
  - Drive `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_control`=000.
  - When `mem_ready`=1: `ir_write`=1 and `pc_write`=1 (PC+1), then → DECODE. Otherwise stay.
- DECODE: no strobes. Next state by opcode:
  - LOAD/ADD/SUB/AND → MEMRD
  - NOT → EXEC
  - STORE → STORE
  - JMP → JUMP
  - JZ → BRZ
- MEMRD: `mem_read`=1, `i_or_d`=1. When `mem_ready`=1: `mdr_write`=1, then → EXEC.
- EXEC: `acc_write`=1, `alu_src_b`=0, `instr_done`=1, then → FETCH. Operand selects by opcode:
  - LOAD: `alu_control`=110.
  - ADD/SUB/AND: `alu_src_a`=1, `alu_control`=000/001/010.
  - NOT: `alu_src_a`=1, `alu_control`=100.
- STORE: `mem_write`=1, `i_or_d`=1. When `mem_ready`=1: `instr_done`=1, then → FETCH.
- JUMP: `alu_src_b`=2, `alu_control`=110, `pc_write`=1, `instr_done`=1, then → FETCH.
- BRZ: `alu_src_a`=1, `alu_control`=101 (ACC onto ALU), `pc_write`=`zero` ⇒ taken only if ACC == 0, `instr_done`=1, then → FETCH.
- Watchdog:
  - A wait counter (width ≥ clog2(MEM_TIMEOUT+1)) clears on entry to any memory state and on `mem_ready`=1.
  - It increments on each cycle in FETCH/MEMRD/STORE with `mem_ready`=0.
  - When the count reaches MEM_TIMEOUT with `mem_ready` still 0 → HALT, `halted`=1.
- HALT: all strobes 0, `halted`=1; left only by reset.

## Timing
- State and counter are registered.
- Strobes are combinational: from state, plus `mem_ready`, `opcode` and `zero` where stated.
- While `rst`=1 and in the cycle after release: state is INIT and every output is 0, including `halted` and `instr_done`.
- Zero-wait latency (`mem_ready` tied 1):
  - LOAD/ADD/SUB/AND: 4 cycles.
  - NOT/STORE/JMP/JZ: 3 cycles.
- Each wait cycle adds one cycle.
- Memory handshake:
  - `mem_read`/`mem_write`/`i_or_d` stay stable until an edge with `mem_ready`=1.
  - `mem_ready` is ignored outside FETCH/MEMRD/STORE.
- `mem_read` and `mem_write` are never both 1.
- Write enables (`ir_write`, `mdr_write`, `pc_write` in FETCH) assert only in the completing cycle.
- Reset mid-instruction aborts immediately: no strobe in the reset cycle, PC/ACC untouched by this block.
- `mem_ready` arriving in the same cycle the counter hits MEM_TIMEOUT counts as success, not timeout.

## Structure
- Shared package `mc_pkg` holds:
  - opcode constants
  - the state enum
  - `alu_control` encodings (shared with the ALU)
  - `alu_src_a`/`alu_src_b` select constants
- One natural sub-module, `mem_watchdog`: wait counter plus timeout compare, parameterised by MEM_TIMEOUT.
- Next-state and output logic stay in `multicycle_controller`.

## Test plan
- Reset release, `mem_ready`=1, opcode 010 → states INIT, FETCH, DECODE, MEMRD, EXEC; `acc_write`=1 with `alu_control`=000 and `alu_src_a`=1 in EXEC; `instr_done` pulses once.
- FETCH with `mem_ready` low for 3 cycles → `mem_read`=1 held 4 cycles; `ir_write`/`pc_write` high only in the 4th.
- JZ with `zero`=1 → `pc_write`=1 in BRZ; repeat with `zero`=0 → `pc_write`=0; both take 3 cycles.
- STORE (001) → `mem_write`=1, `i_or_d`=1; `mem_read` never 1 during STORE; 3 cycles total.
- MEM_TIMEOUT=4, `mem_ready` stuck 0 in MEMRD → HALT after 4 wait cycles; `halted`=1 sticky; later `mem_ready`=1 has no effect; `rst` returns to INIT.
- `rst` asserted during MEMRD wait → all outputs 0 immediately; after release FETCH begins 2 cycles later.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle accumulator controller and its ALU.
// Opcodes, FSM states, ALU operations and operand-select codes.
package mc_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_NOT   = 3'b101;
  localparam logic [2:0] OP_JMP   = 3'b110;
  localparam logic [2:0] OP_JZ    = 3'b111;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_EXEC,
    S_STORE,
    S_JUMP,
    S_BRZ,
    S_HALT
  } state_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_NOTA  = 3'b100;
  localparam logic [2:0] ALU_PASSA = 3'b101;
  localparam logic [2:0] ALU_PASSB = 3'b110;

  localparam logic SRCA_PC  = 1'b0;
  localparam logic SRCA_ACC = 1'b1;

  localparam logic [1:0] SRCB_MDR = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_STORE);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive wait cycles of one memory request and flags a timeout.
// A MEM_TIMEOUT of 0 disables the timeout entirely.
module mem_watchdog
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic mem_ready_i,
  output logic timeout_o
);

  localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);
  localparam logic EN = (MEM_TIMEOUT != 0);

  logic [W-1:0] cnt_q, cnt_d;
  logic         waiting;

  assign waiting = active_i && !mem_ready_i;

  // Anything other than a stalled request restarts the count.
  always_comb begin
    cnt_d = '0;
    if (waiting) begin
      if (cnt_q != LIMIT) cnt_d = cnt_q + W'(1);
      else                cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout_o = EN && waiting && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the 16-bit multi-cycle accumulator processor.
// Sequences fetch/decode/memory/execute and drives the ALU and its muxes.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       acc_write,
  output logic       pc_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       halted
);

  state_e state_q, state_d;
  logic   timeout;

  mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wdog (
    .clk        (clk),
    .rst        (rst),
    .active_i   (is_mem_state(state_q)),
    .mem_ready_i(mem_ready),
    .timeout_o  (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    mdr_write   = 1'b0;
    acc_write   = 1'b0;
    pc_write    = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_MDR;
    alu_control = ALU_ADD;
    instr_done  = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      S_INIT: state_d = S_FETCH;

      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = SRCB_ONE;
        alu_control = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d = S_HALT;
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_STORE: state_d = S_STORE;
          OP_NOT:   state_d = S_EXEC;
          OP_JMP:   state_d = S_JUMP;
          OP_JZ:    state_d = S_BRZ;
          default:  state_d = S_MEMRD;
        endcase
      end

      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          mdr_write = 1'b1;
          state_d   = S_EXEC;
        end else if (timeout) begin
          state_d = S_HALT;
        end
      end

      S_EXEC: begin
        acc_write  = 1'b1;
        alu_src_b  = SRCB_MDR;
        instr_done = 1'b1;
        state_d    = S_FETCH;
        case (opcode)
          OP_ADD: begin
            alu_src_a   = SRCA_ACC;
            alu_control = ALU_ADD;
          end
          OP_SUB: begin
            alu_src_a   = SRCA_ACC;
            alu_control = ALU_SUB;
          end
          OP_AND: begin
            alu_src_a   = SRCA_ACC;
            alu_control = ALU_AND;
          end
          OP_NOT: begin
            alu_src_a   = SRCA_ACC;
            alu_control = ALU_NOTA;
          end
          default: alu_control = ALU_PASSB;
        endcase
      end

      S_STORE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (timeout) begin
          state_d = S_HALT;
        end
      end

      S_JUMP: begin
        alu_src_b   = SRCB_IMM;
        alu_control = ALU_PASSB;
        pc_write    = 1'b1;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end

      // The ALU passes ACC through, so zero reflects ACC == 0.
      S_BRZ: begin
        alu_src_a   = SRCA_ACC;
        alu_control = ALU_PASSA;
        pc_write    = zero;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_INIT;
    endcase
  end

endmodule
